// File: rtl/neuron_requant.sv
// Accumulates NUM_INPUTS signed products onto a neuron bias, then requantizes the
// sum to a signed OUT_WIDTH activation with round-half-up shift, optional ReLU and clamp.
module neuron_requant #(
   parameter int BIAS_WIDTH  = 32,
   parameter int OUT_WIDTH   = 8,
   parameter int NUM_INPUTS  = 784,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic                         CLK,
   input  logic                         RESETN,
   input  logic                         START,
   input  logic signed [BIAS_WIDTH-1:0] BIAS,
   input  logic [SHIFT_WIDTH-1:0]       SHIFT,
   input  logic                         RELU_EN,
   input  logic                         PROD_VALID,
   output logic                         PROD_READY,
   input  logic signed [BIAS_WIDTH-1:0] PROD,
   output logic                         OUT_VALID,
   input  logic                         OUT_READY,
   output logic [OUT_WIDTH-1:0]         OUT_DATA,
   output logic                         BUSY,
   output logic                         OVF
);

   localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

   localparam logic signed [BIAS_WIDTH-1:0] ACC_MAX = {1'b0, {(BIAS_WIDTH-1){1'b1}}};
   localparam logic signed [BIAS_WIDTH-1:0] ACC_MIN = {1'b1, {(BIAS_WIDTH-1){1'b0}}};
   localparam logic signed [BIAS_WIDTH:0] OUT_MAX =
      {{(BIAS_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [BIAS_WIDTH:0] OUT_MIN =
      {{(BIAS_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic signed [BIAS_WIDTH:0] ONE = 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      REQUANT,
      OUTPUT
   } state_e;

   state_e                       state_q, state_d;
   logic signed [BIAS_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
   logic                         relu_q, relu_d;
   logic                         ovf_q, ovf_d;
   logic [OUT_WIDTH-1:0]         out_q, out_d;

   logic signed [BIAS_WIDTH:0]   sum_ext;
   logic signed [BIAS_WIDTH-1:0] sum_sat;
   logic                         sum_ovf;
   logic signed [BIAS_WIDTH:0]   rnd;
   logic signed [BIAS_WIDTH:0]   r_sum;
   logic signed [BIAS_WIDTH:0]   r_shift;
   logic signed [BIAS_WIDTH:0]   r_relu;
   logic [OUT_WIDTH-1:0]         r_out;

   // Saturating accumulate: a sign mismatch between the two top bits of the
   // widened sum means the result left the BIAS_WIDTH range.
   always_comb begin
      sum_ext = {acc_q[BIAS_WIDTH-1], acc_q} + {PROD[BIAS_WIDTH-1], PROD};
      sum_sat = sum_ext[BIAS_WIDTH-1:0];
      sum_ovf = 1'b0;
      if (sum_ext[BIAS_WIDTH] != sum_ext[BIAS_WIDTH-1]) begin
         sum_ovf = 1'b1;
         sum_sat = sum_ext[BIAS_WIDTH] ? ACC_MIN : ACC_MAX;
      end
   end

   always_comb begin
      rnd = '0;
      if (shift_q != '0) begin
         rnd = ONE << (shift_q - SHIFT_WIDTH'(1));
      end
      r_sum   = {acc_q[BIAS_WIDTH-1], acc_q} + rnd;
      r_shift = r_sum >>> shift_q;
      r_relu  = (relu_q && r_shift[BIAS_WIDTH]) ? '0 : r_shift;
      if (r_relu > OUT_MAX) begin
         r_out = OUT_MAX[OUT_WIDTH-1:0];
      end else if (r_relu < OUT_MIN) begin
         r_out = OUT_MIN[OUT_WIDTH-1:0];
      end else begin
         r_out = r_relu[OUT_WIDTH-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      relu_d  = relu_q;
      ovf_d   = ovf_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               acc_d   = BIAS;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               shift_d = SHIFT;
               relu_d  = RELU_EN;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (PROD_VALID) begin
               acc_d = sum_sat;
               cnt_d = cnt_q + CNT_W'(1);
               if (sum_ovf) begin
                  ovf_d = 1'b1;
               end
               if (cnt_q == LAST_CNT) begin
                  state_d = REQUANT;
               end
            end
         end
         REQUANT: begin
            out_d   = r_out;
            state_d = OUTPUT;
         end
         OUTPUT: begin
            if (OUT_READY) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
         ovf_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         relu_q  <= relu_d;
         ovf_q   <= ovf_d;
         out_q   <= out_d;
      end
   end

   assign PROD_READY = (state_q == ACCUM);
   assign OUT_VALID  = (state_q == OUTPUT);
   assign BUSY       = (state_q != IDLE);
   assign OUT_DATA   = out_q;
   assign OVF        = ovf_q;

endmodule
